// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam int NUM_REQ   = 2;
  localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/mem_arb_sat_counter.sv
// Saturating up-counter used for arbitration statistics.
// Latency: count updates one cycle after inc_i is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module mem_arb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter (with lock) sharing one single-port data memory between two requesters.
// Latency: grant and memory drive combinational; read response one cycle after acceptance.
// Backpressure: one ready per cycle; lock owner blocks the other side. MEM_ARB_PERF_EN adds oConflictCount.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iReq0Valid,
  input  logic                  iReq1Valid,
  output logic                  oReq0Ready,
  output logic                  oReq1Ready,
  input  logic                  iReq0Write,
  input  logic                  iReq1Write,
  input  logic                  iReq0Lock,
  input  logic                  iReq1Lock,
  input  logic [ADDR_WIDTH-1:0] iReq0Addr,
  input  logic [ADDR_WIDTH-1:0] iReq1Addr,
  input  logic [DATA_WIDTH-1:0] iReq0WData,
  input  logic [DATA_WIDTH-1:0] iReq1WData,
  output logic                  oRsp0Valid,
  output logic                  oRsp1Valid,
  output logic [DATA_WIDTH-1:0] oRspRData,
  output logic                  oMemWE,
  output logic [ADDR_WIDTH-1:0] oMemA,
  output logic [DATA_WIDTH-1:0] oMemWD,
  input  logic [DATA_WIDTH-1:0] iMemRD
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  oConflictCount
`endif
);

  arb_state_t         state_q, state_d;
  req_id_t            rr_q, rr_d;
  logic               rsp0_q, rsp0_d;
  logic               rsp1_q, rsp1_d;
  logic [NUM_REQ-1:0] gnt;
  req_id_t            gnt_id;
  logic               gnt_any;
  logic               gnt_lock;
  logic               gnt_write;

  // Grant decision: lock owner only, else round-robin on contention, else whoever asks.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (iReq0Valid && iReq1Valid) begin
            gnt[rr_q] = 1'b1;
          end else begin
            gnt = {iReq1Valid, iReq0Valid};
          end
        end
        LOCK0:   gnt[0] = iReq0Valid;
        LOCK1:   gnt[1] = iReq1Valid;
        default: gnt = '0;
      endcase
    end
  end

  assign gnt_any   = |gnt;
  assign gnt_id    = gnt[1];
  assign gnt_lock  = gnt[1] ? iReq1Lock  : iReq0Lock;
  assign gnt_write = gnt[1] ? iReq1Write : iReq0Write;

  // Next state: any grant points round-robin at the other side; the lock bit picks LOCKn or ARB.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    rsp0_d  = gnt[0] && !iReq0Write;
    rsp1_d  = gnt[1] && !iReq1Write;
    if (gnt_any) begin
      rr_d = ~gnt_id;
      if (gnt_lock) begin
        state_d = gnt_id ? LOCK1 : LOCK0;
      end else begin
        state_d = ARB;
      end
    end
  end

  // State, pointer and pending-response registers; reset drops responses and releases locks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      rr_q    <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
    end
  end

  assign oReq0Ready = gnt[0];
  assign oReq1Ready = gnt[1];

  assign oMemWE = gnt_any && gnt_write;
  assign oMemA  = gnt[0] ? iReq0Addr  : (gnt[1] ? iReq1Addr  : '0);
  assign oMemWD = gnt[0] ? iReq0WData : (gnt[1] ? iReq1WData : '0);

  // Responses are suppressed while reset is held so a read issued just before reset never returns.
  assign oRsp0Valid = rsp0_q && !rst;
  assign oRsp1Valid = rsp1_q && !rst;
  assign oRspRData  = (oRsp0Valid || oRsp1Valid) ? iMemRD : '0;

`ifdef MEM_ARB_PERF_EN
  // Contention means both asking: exactly one of them is refused that cycle.
  mem_arb_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_conflict_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (iReq0Valid && iReq1Valid && !rst),
    .count_o (oConflictCount)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, back-to-back reads, randomized model check.
// Latency: expectations sampled on the falling edge, responses one cycle after acceptance.
// Backpressure: modelled requesters hold valid/payload until accepted.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, w0, w1, l0, l1;
  logic [31:0] a0, a1, d0, d1;
  logic        r0, r1, rv0, rv1, we;
  logic [31:0] rdata, ma, mwd, mrd;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .iReq0Valid (v0),
    .iReq1Valid (v1),
    .oReq0Ready (r0),
    .oReq1Ready (r1),
    .iReq0Write (w0),
    .iReq1Write (w1),
    .iReq0Lock  (l0),
    .iReq1Lock  (l1),
    .iReq0Addr  (a0),
    .iReq1Addr  (a1),
    .iReq0WData (d0),
    .iReq1WData (d1),
    .oRsp0Valid (rv0),
    .oRsp1Valid (rv1),
    .oRspRData  (rdata),
    .oMemWE     (we),
    .oMemA      (ma),
    .oMemWD     (mwd),
    .iMemRD     (mrd)
`ifdef MEM_ARB_PERF_EN
    ,
    .oConflictCount (cnt)
`endif
  );

  // Initial memory contents are a fixed function of the address.
  function automatic logic [31:0] fv(input logic [31:0] addr);
    return 32'hA500_0000 ^ addr;
  endfunction

  // Single-port memory with one-cycle read latency (read returns the pre-write value).
  bit [31:0] ram     [64];
  bit        written [64];
  always @(posedge clk) begin
    mrd <= written[ma[7:2]] ? ram[ma[7:2]] : fv(ma);
    if (we) begin
      ram[ma[7:2]]     <= mwd;
      written[ma[7:2]] <= 1'b1;
    end
  end

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit          rs, iv0, iv1, iw0, iw1, il0, il1;
    logic [31:0] ia0, ia1, iwd0;
    bit          er0, er1, ewe;
    logic [31:0] ea;
    bit          erv0, erv1;
    logic [31:0] erd;
    int          ecnt;
  } vec_t;

  function automatic vec_t mk(bit rs, bit iv0, bit iv1, bit iw0, bit iw1, bit il0, bit il1,
                              logic [31:0] ia0, logic [31:0] ia1, logic [31:0] iwd0,
                              bit er0, bit er1, bit ewe, logic [31:0] ea,
                              bit erv0, bit erv1, logic [31:0] erd, int ecnt);
    vec_t t;
    t.rs = rs; t.iv0 = iv0; t.iv1 = iv1; t.iw0 = iw0; t.iw1 = iw1; t.il0 = il0; t.il1 = il1;
    t.ia0 = ia0; t.ia1 = ia1; t.iwd0 = iwd0;
    t.er0 = er0; t.er1 = er1; t.ewe = ewe; t.ea = ea;
    t.erv0 = erv0; t.erv1 = erv1; t.erd = erd; t.ecnt = ecnt;
    return t;
  endfunction

  vec_t tbl [24];

  // Randomized-phase reference model state
  bit          bz [2];
  bit          rw [2];
  bit          rl [2];
  logic [31:0] rad [2];
  logic [31:0] rwd [2];
  logic [31:0] mdl_mem [64];
  int          owner, rr, g, pend_id;
  bit          pend;
  logic [31:0] pend_dat;
  int          mcnt;

  initial begin
    // rst v0 v1 w0 w1 l0 l1 a0 a1 wd0 | r0 r1 we addr | rv0 rv1 rdata | cnt
    tbl[0]  = mk(1,1,1,0,0,0,0, 32'h10, 32'h20, 0,            0,0,0, 32'h00, 0,0, 0,                -1);
    tbl[1]  = mk(0,1,1,0,0,0,0, 32'h10, 32'h20, 0,            1,0,0, 32'h10, 0,0, 0,                 0);
    tbl[2]  = mk(0,1,1,0,0,0,0, 32'h10, 32'h20, 0,            0,1,0, 32'h20, 1,0, fv(32'h10),       -1);
    tbl[3]  = mk(0,1,1,0,0,0,0, 32'h10, 32'h20, 0,            1,0,0, 32'h10, 0,1, fv(32'h20),       -1);
    tbl[4]  = mk(0,1,1,0,0,0,0, 32'h10, 32'h20, 0,            0,1,0, 32'h20, 1,0, fv(32'h10),       -1);
    tbl[5]  = mk(0,1,0,1,0,0,0, 32'h40, 32'h00, 32'hDEADBEEF, 1,0,1, 32'h40, 0,1, fv(32'h20),        4);
    tbl[6]  = mk(0,0,1,0,0,0,0, 32'h00, 32'h40, 0,            0,1,0, 32'h40, 0,0, 0,                -1);
    tbl[7]  = mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 0,            0,0,0, 32'h00, 0,1, 32'hDEADBEEF,     -1);
    tbl[8]  = mk(0,1,0,0,0,0,0, 32'h14, 32'h00, 0,            1,0,0, 32'h14, 0,0, 0,                -1);
    tbl[9]  = mk(0,1,1,0,0,0,1, 32'h10, 32'h24, 0,            0,1,0, 32'h24, 1,0, fv(32'h14),       -1);
    tbl[10] = mk(0,1,1,0,0,0,1, 32'h10, 32'h24, 0,            0,1,0, 32'h24, 0,1, fv(32'h24),       -1);
    tbl[11] = mk(0,1,1,0,0,0,1, 32'h10, 32'h24, 0,            0,1,0, 32'h24, 0,1, fv(32'h24),       -1);
    tbl[12] = mk(0,1,1,0,0,0,0, 32'h10, 32'h24, 0,            0,1,0, 32'h24, 0,1, fv(32'h24),       -1);
    tbl[13] = mk(0,1,0,0,0,0,0, 32'h10, 32'h00, 0,            1,0,0, 32'h10, 0,1, fv(32'h24),        8);
    tbl[14] = mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 0,            0,0,0, 32'h00, 1,0, fv(32'h10),       -1);
    tbl[15] = mk(0,1,0,0,0,0,0, 32'h18, 32'h00, 0,            1,0,0, 32'h18, 0,0, 0,                -1);
    tbl[16] = mk(1,1,1,0,0,0,0, 32'h18, 32'h28, 0,            0,0,0, 32'h00, 0,0, 0,                -1);
    tbl[17] = mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 0,            0,0,0, 32'h00, 0,0, 0,                 0);
    tbl[18] = mk(0,1,1,0,0,0,0, 32'h1C, 32'h2C, 0,            1,0,0, 32'h1C, 0,0, 0,                -1);
    tbl[19] = mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 0,            0,0,0, 32'h00, 1,0, fv(32'h1C),        1);
    tbl[20] = mk(0,0,1,0,0,0,1, 32'h00, 32'h30, 0,            0,1,0, 32'h30, 0,0, 0,                -1);
    tbl[21] = mk(1,0,0,0,0,0,0, 32'h00, 32'h00, 0,            0,0,0, 32'h00, 0,0, 0,                -1);
    tbl[22] = mk(0,1,1,0,0,0,0, 32'h34, 32'h38, 0,            1,0,0, 32'h34, 0,0, 0,                 0);
    tbl[23] = mk(0,0,0,0,0,0,0, 32'h00, 32'h00, 0,            0,0,0, 32'h00, 1,0, fv(32'h34),       -1);

    d1 = '0;
    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].rs; v0 = tbl[i].iv0; v1 = tbl[i].iv1; w0 = tbl[i].iw0; w1 = tbl[i].iw1;
      l0 = tbl[i].il0; l1 = tbl[i].il1; a0 = tbl[i].ia0; a1 = tbl[i].ia1; d0 = tbl[i].iwd0;
      @(negedge clk);
      chk("ready0", i, 32'(r0), 32'(tbl[i].er0));
      chk("ready1", i, 32'(r1), 32'(tbl[i].er1));
      chk("mem_we", i, 32'(we), 32'(tbl[i].ewe));
      chk("mem_addr", i, ma, tbl[i].ea);
      chk("mem_wdata", i, mwd, tbl[i].er0 ? tbl[i].iwd0 : 32'h0);
      chk("rsp0_valid", i, 32'(rv0), 32'(tbl[i].erv0));
      chk("rsp1_valid", i, 32'(rv1), 32'(tbl[i].erv1));
      chk("rsp_data", i, rdata, tbl[i].erd);
`ifdef MEM_ARB_PERF_EN
      if (tbl[i].ecnt >= 0) chk("conflict_cnt", i, 32'(cnt), tbl[i].ecnt);
`endif
      @(posedge clk); #1;
    end

    // Single requester streaming 8 reads back-to-back
    for (int i = 0; i < 9; i++) begin
      rst = 1'b0; v0 = 1'b0; l1 = 1'b0; w1 = 1'b0;
      v1 = (i < 8);
      a1 = 32'h50 + 32'(4 * i);
      @(negedge clk);
      if (i < 8) chk("stream_ready1", i, 32'(r1), 32'h1);
      chk("stream_rsp0", i, 32'(rv0), 32'h0);
      if (i > 0) begin
        chk("stream_rsp1", i, 32'(rv1), 32'h1);
        chk("stream_data", i, rdata, fv(32'h50 + 32'(4 * (i - 1))));
      end
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 64; i++) mdl_mem[i] = fv(32'(i * 4));
    bz[0] = 0; bz[1] = 0;
    owner = -1; rr = 0; pend = 0; pend_id = 0; pend_dat = '0; mcnt = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!bz[n] && ($urandom_range(0, 99) < 60)) begin
          bz[n]  = 1;
          rw[n]  = ($urandom_range(0, 99) < 40);
          rl[n]  = ($urandom_range(0, 99) < 25);
          rad[n] = 32'h80 + 32'(4 * $urandom_range(0, 15));
          rwd[n] = $urandom;
        end
      end
      rst = (c == 0) || ($urandom_range(0, 99) == 0);
      v0 = bz[0]; w0 = rw[0]; l0 = rl[0]; a0 = rad[0]; d0 = rwd[0];
      v1 = bz[1]; w1 = rw[1]; l1 = rl[1]; a1 = rad[1]; d1 = rwd[1];

      g = -1;
      if (!rst) begin
        if (owner >= 0) begin
          if (bz[owner]) g = owner;
        end else if (bz[0] && bz[1]) g = rr;
        else if (bz[0]) g = 0;
        else if (bz[1]) g = 1;
      end

      @(negedge clk);
      chk("rnd_ready0", c, 32'(r0), 32'(g == 0));
      chk("rnd_ready1", c, 32'(r1), 32'(g == 1));
      chk("rnd_mem_we", c, 32'(we), (g >= 0) ? 32'(rw[g]) : 32'h0);
      chk("rnd_mem_addr", c, ma, (g >= 0) ? rad[g] : 32'h0);
      chk("rnd_mem_wdata", c, mwd, (g >= 0) ? rwd[g] : 32'h0);
      chk("rnd_rsp0", c, 32'(rv0), 32'(!rst && pend && pend_id == 0));
      chk("rnd_rsp1", c, 32'(rv1), 32'(!rst && pend && pend_id == 1));
      chk("rnd_rsp_data", c, rdata, (!rst && pend) ? pend_dat : 32'h0);
`ifdef MEM_ARB_PERF_EN
      if (c > 0) chk("rnd_conflict_cnt", c, 32'(cnt), mcnt);
`endif

      if (rst) begin
        owner = -1; rr = 0; pend = 0; mcnt = 0;
      end else begin
        if (bz[0] && bz[1] && mcnt < 65535) mcnt++;
        pend = 0;
        if (g >= 0) begin
          if (rw[g]) begin
            mdl_mem[rad[g][7:2]] = rwd[g];
          end else begin
            pend = 1; pend_id = g; pend_dat = mdl_mem[rad[g][7:2]];
          end
          rr    = 1 - g;
          owner = rl[g] ? g : -1;
          bz[g] = 0;
        end
      end
      @(posedge clk); #1;
    end

`ifdef MEM_ARB_PERF_EN
    // Sustained contention must saturate the conflict counter rather than wrap
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; w0 = 1'b0; w1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("conflict_saturate", 70000, 32'(cnt), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
